// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
//   Buffers host command codes in a small FIFO and issues them one at a time
//   to the LCD image controller. An issue happens only while the controller
//   reports not busy. A write command (4'h0) is terminal: the block then waits
//   for the controller's done (or a timeout) and locks until reset.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high
//   host_cmd   : host command code
//   host_valid : host offers host_cmd this cycle
//   host_ready : FIFO accepts this cycle (registered)
//   cmd        : command to the controller (registered, NOP_CMD when idle)
//   cmd_valid  : one-cycle pulse on the first cycle of an issued command
//   busy       : controller busy; 0 means it samples cmd
//   done       : controller finished writing the image
//   seq_done   : sequence completed (done seen or timeout)
//   cmd_count  : commands issued, saturating at 255
//   dropped    : sticky, a host offer was refused
//   timeout    : sticky, done did not arrive in time
module lcd_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [3:0]  NOP_CMD      = 4'hF,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] host_cmd,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  output logic       seq_done,
  output logic [7:0] cmd_count,
  output logic       dropped,
  output logic       timeout
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned WW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;
  localparam logic [3:0]  WRITE_CMD = 4'h0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t          state;
  state_t          state_n;

  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;
  logic [HW-1:0]   hold_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [3:0]      head;
  logic            push;
  logic            pop;
  logic            timeout_hit;
  logic [3:0]      cmd_n;
  logic            cmd_valid_n;

  assign head = mem[rd_ptr];
  assign push = host_valid && host_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; pop is the issue decision
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if ((count != '0) && !busy) begin
          pop     = 1'b1;
          state_n = (head == WRITE_CMD) ? S_WAIT_DONE : S_HOLD;
        end
      end
      S_HOLD: begin
        // hold_cnt starts at 0 on the cycle after issue, so the issued code
        // stays on cmd for HOLD_CYC cycles including the issue cycle
        if (hold_cnt == HW'(HOLD_CYC - 1)) begin
          state_n = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (done) begin
          state_n = S_FINISH;
        end else if (wait_cnt == WW'(DONE_TIMEOUT - 1)) begin
          state_n     = S_FINISH;
          timeout_hit = 1'b1;
        end
      end
      S_FINISH: begin
        state_n = S_FINISH;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Output logic: next values for the registered command port, plus seq_done
  always_comb begin
    cmd_n       = cmd;
    cmd_valid_n = 1'b0;
    if (pop) begin
      cmd_n       = head;
      cmd_valid_n = 1'b1;
    end else if ((state_n == S_IDLE) || (state_n == S_FINISH)) begin
      cmd_n = NOP_CMD;
    end
    seq_done = (state == S_FINISH);
  end

  // Occupancy; entering or staying in FINISH flushes the FIFO
  always_comb begin
    count_n = count;
    if (state_n == S_FINISH) begin
      count_n = '0;
    end else if (push && !pop) begin
      count_n = count + CW'(1);
    end else if (!push && pop) begin
      count_n = count - CW'(1);
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= host_cmd;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_cnt   <= '0;
      wait_cnt   <= '0;
      cmd        <= NOP_CMD;
      cmd_valid  <= 1'b0;
      host_ready <= 1'b0;
      cmd_count  <= '0;
      dropped    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      count      <= count_n;
      cmd        <= cmd_n;
      cmd_valid  <= cmd_valid_n;
      // Registered ready reflects the post-edge occupancy, so a full FIFO
      // deasserts ready in the cycle right after the filling push
      host_ready <= (count_n < CW'(FIFO_DEPTH)) && (state_n != S_FINISH);

      if (state_n == S_FINISH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end

      hold_cnt <= ((state == S_HOLD) && (state_n == S_HOLD)) ? hold_cnt + HW'(1) : '0;
      wait_cnt <= ((state == S_WAIT_DONE) && (state_n == S_WAIT_DONE)) ? wait_cnt + WW'(1) : '0;

      if (pop && (cmd_count != 8'hFF)) begin
        cmd_count <= cmd_count + 8'd1;
      end
      if (host_valid && !host_ready) begin
        dropped <= 1'b1;
      end
      if (timeout_hit) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Testbench for lcd_cmd_sequencer: directed scenarios and randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_lcd_cmd_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned TMO   = 15;
  localparam logic [3:0]  NOP   = 4'hF;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       seq_done;
  logic [7:0] cmd_count;
  logic       dropped;
  logic       timeout;

  always #5 clk = ~clk;

  lcd_cmd_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .NOP_CMD     (NOP),
    .HOLD_CYC    (HOLD),
    .DONE_TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .host_cmd  (host_cmd),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .busy      (busy),
    .done      (done),
    .seq_done  (seq_done),
    .cmd_count (cmd_count),
    .dropped   (dropped),
    .timeout   (timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pending commands in a queue, remaining hold cycles,
  // elapsed wait cycles, and flags.
  logic [3:0] mq[$];
  logic [3:0] m_cmd;
  bit         m_valid, m_ready, m_drop, m_to, m_fin, m_wait;
  int         m_hold, m_wcyc, m_cnt;

  task automatic model_edge();
    bit push;
    if (reset) begin
      mq.delete();
      m_cmd = NOP; m_valid = 0; m_ready = 0; m_drop = 0; m_to = 0;
      m_fin = 0; m_wait = 0; m_hold = 0; m_wcyc = 0; m_cnt = 0;
      return;
    end
    push = host_valid && m_ready;
    if (host_valid && !m_ready) m_drop = 1;
    m_valid = 0;
    if (m_fin) begin
      m_cmd = NOP;
    end else if (m_wait) begin
      if (done) begin
        m_fin = 1; m_wait = 0; m_cmd = NOP;
      end else if (m_wcyc + 1 == TMO) begin
        m_to = 1; m_fin = 1; m_wait = 0; m_cmd = NOP;
      end else begin
        m_wcyc++;
      end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_cmd = NOP;
    end else if (mq.size() > 0 && !busy) begin
      m_cmd   = mq.pop_front();
      m_valid = 1;
      if (m_cnt < 255) m_cnt++;
      if (m_cmd == 4'h0) begin
        m_wait = 1; m_wcyc = 0;
      end else begin
        m_hold = HOLD;
      end
    end
    if (m_fin) mq.delete();
    else if (push) mq.push_back(host_cmd);
    m_ready = (mq.size() < DEPTH) && !m_fin;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cmd",        cmd,        m_cmd);
    check("cmd_valid",  cmd_valid,  m_valid);
    check("host_ready", host_ready, m_ready);
    check("seq_done",   seq_done,   m_fin);
    check("cmd_count",  cmd_count,  m_cnt);
    check("dropped",    dropped,    m_drop);
    check("timeout",    timeout,    m_to);
  endtask

  task automatic do_reset();
    reset = 1; host_valid = 0; busy = 0; done = 0;
    step();
    reset = 0;
    step();
  endtask

  task automatic push_one(input logic [3:0] c);
    host_valid = 1; host_cmd = c;
    step();
    host_valid = 0;
  endtask

  task automatic wait_issue(input string tag);
    bit seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cmd_valid) begin
        seen = 1;
        break;
      end
    end
    check(tag, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1; host_valid = 0; host_cmd = 4'h0; busy = 0; done = 0;
    step();
    step();
    check("rst_cmd",   cmd,        NOP);
    check("rst_ready", host_ready, 0);
    check("rst_cnt",   cmd_count,  0);
    reset = 0;
    step();
    check("ready_after_rst", host_ready, 1);

    // Basic issue
    push_one(4'h1);
    step();
    check("basic_issue", {cmd_valid, cmd}, {1'b1, 4'h1});
    step();
    check("basic_hold", {cmd_valid, cmd}, {1'b0, 4'h1});
    step();
    check("basic_nop", cmd, NOP);
    check("basic_count", cmd_count, 1);

    // Busy gating and full FIFO
    busy = 1;
    for (int i = 0; i < 9; i++) begin
      host_valid = 1; host_cmd = 4'($urandom_range(1, 15));
      step();
      if (i == 7) check("full_ready", host_ready, 0);
    end
    host_valid = 0;
    check("full_dropped", dropped, 1);
    busy = 0;
    repeat (30) step();
    check("drain_count", cmd_count, 9);

    // Random non-write traffic
    for (int i = 0; i < 300; i++) begin
      host_valid = 1'($urandom_range(0, 1));
      host_cmd   = 4'($urandom_range(1, 15));
      busy       = ($urandom_range(0, 3) == 0);
      done       = 1'($urandom_range(0, 1));
      step();
    end
    host_valid = 0; busy = 0; done = 0;
    repeat (30) step();
    check("early_done_ignored", seq_done, 0);

    // Write completion
    do_reset();
    push_one(4'h5);
    push_one(4'h0);
    push_one(4'h3);
    for (int i = 0; i < 30; i++) begin
      if (cmd_valid && cmd == 4'h0) break;
      step();
    end
    check("write_issue", {cmd_valid, cmd}, {1'b1, 4'h0});
    repeat (9) step();
    check("write_held", cmd, 4'h0);
    done = 1;
    step();
    done = 0;
    check("write_seq_done", seq_done, 1);
    repeat (5) step();
    check("write_count", cmd_count, 2);
    check("write_ready", host_ready, 0);
    check("write_to", timeout, 0);

    // Timeout
    do_reset();
    push_one(4'h0);
    wait_issue("to_issue");
    for (int k = 1; k < TMO; k++) step();
    check("to_early", seq_done, 0);
    step();
    check("to_flag", timeout, 1);
    check("to_seq_done", seq_done, 1);
    repeat (3) step();

    // Reset during HOLD
    do_reset();
    push_one(4'h6);
    wait_issue("mid_issue");
    step();
    check("mid_hold", cmd, 4'h6);
    reset = 1;
    step();
    reset = 0;
    check("mid_cmd", cmd, NOP);
    check("mid_flags", {cmd_valid, seq_done, dropped, timeout}, 4'b0000);
    step();
    push_one(4'h7);
    step();
    check("mid_fresh", {cmd_valid, cmd}, {1'b1, 4'h7});
    repeat (3) step();

    // Saturation
    do_reset();
    for (int i = 0; i < 820; i++) begin
      host_valid = 1; host_cmd = 4'($urandom_range(1, 15));
      step();
    end
    host_valid = 0;
    repeat (30) step();
    check("sat_count", cmd_count, 255);

    // Random traffic including writes, done pulses and resets
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      host_valid = 1'($urandom_range(0, 1));
      host_cmd   = 4'($urandom_range(0, 15));
      busy       = ($urandom_range(0, 3) == 0);
      done       = ($urandom_range(0, 19) == 0);
      step();
    end
    reset = 0; host_valid = 0; busy = 0; done = 0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Command sequencer between a host command source and the LCD image controller. It buffers host commands in a small FIFO and issues them one at a time on the controller's `cmd` port, using the controller's `busy` handshake. It drives a harmless no-op code whenever no command is pending. A write command (`4'h0`) is treated as terminal: the block waits for the controller's `done`, then locks.

## Interface

Parameters:
- `FIFO_DEPTH`, 8: host command FIFO entries; power of two, 2 to 16.
- `NOP_CMD`, 4'hF: code driven on `cmd` when idle; the controller ignores it.
- `HOLD_CYC`, 2: cycles `cmd` is held after issue, covering the controller's decode and process cycles.
- `DONE_TIMEOUT`, 255: maximum wait cycles for `done` after a write command.

Ports:
- `clk`, in, 1: the only clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `host_cmd`, in, 4: host command code.
- `host_valid`, in, 1: host offers `host_cmd` this cycle.
- `host_ready`, out, 1: FIFO accepts this cycle. Registered.
- `cmd`, out, 4: command to the LCD controller. Registered.
- `cmd_valid`, out, 1: one-cycle pulse marking the first cycle of an issued command.
- `busy`, in, 1: controller busy; 0 means the controller is sampling `cmd`.
- `done`, in, 1: controller finished writing the image.
- `seq_done`, out, 1: level; the sequence completed (done seen or timeout).
- `cmd_count`, out, 8: number of commands issued, saturating at 255.
- `dropped`, out, 1: sticky; a host offer was refused.
- `timeout`, out, 1: sticky; `done` did not arrive within `DONE_TIMEOUT` cycles.

## Operation

- **FIFO**: `FIFO_DEPTH` x 4 bits, with read/write pointers and an occupancy count.
  - A push happens when `host_valid && host_ready`.
  - `host_ready` = (count < `FIFO_DEPTH`) && state != FINISH, computed from registered values.
  - There is no pass-through. A simultaneous push and pop leaves count unchanged.
- **dropped**: set when `host_valid && !host_ready`; cleared only by reset.
- **States**:
  - IDLE: `cmd` = `NOP_CMD`. If count > 0 and `busy` == 0, pop the FIFO head into the `cmd` register, pulse `cmd_valid`, increment `cmd_count`, then go to HOLD, or to WAIT_DONE if the head is `4'h0`.
  - HOLD: `cmd` is held for `HOLD_CYC` cycles including the issue cycle, then returns to `NOP_CMD`. After HOLD the state is IDLE. `busy` is not re-checked in HOLD.
  - WAIT_DONE: `cmd` is held at `4'h0`. A wait counter increments each cycle. When `done` == 1, go to FINISH. When the counter reaches `DONE_TIMEOUT`, set `timeout` and go to FINISH.
  - FINISH: terminal until reset. `seq_done` = 1, the FIFO is flushed (count forced to 0), `host_ready` = 0, and `cmd` = `NOP_CMD`.
- **Command codes** are forwarded unmodified. The block interprets only `4'h0`.
- **cmd_count** saturates at 255 and does not wrap.
- **Reset** values:
  - `cmd` = `NOP_CMD`; `cmd_valid`, `host_ready`, `seq_done`, `dropped`, `timeout` = 0; `cmd_count` = 0.
  - FIFO is empty and state is IDLE.
  - `host_ready` rises in the first cycle after reset is released.
  - Reset mid-HOLD or mid-WAIT_DONE aborts immediately; no partial command survives.

## Timing

- **Push to issue**: push at edge t with the FIFO previously empty and `busy` = 0 at edge t+1 gives `cmd`/`cmd_valid` valid after edge t+1. Minimum latency is 1 cycle.
- **Issue spacing**: back-to-back issues are at least `HOLD_CYC` + 1 cycles apart (HOLD cycles, then an IDLE re-evaluation).
- **Busy gating**: while `busy` = 1 in IDLE, nothing issues and the FIFO keeps filling. Full gives `host_ready` = 0 in the cycle after the `FIFO_DEPTH`th push.
- **seq_done** rises one cycle after `done` is sampled at 1 in WAIT_DONE.
- **Timeout**: entering WAIT_DONE at edge w with `done` held 0 gives `timeout` and `seq_done` high after edge w + `DONE_TIMEOUT`.
- **Early done**: a `done` pulse in any state other than WAIT_DONE is ignored.

## Test plan

- **Basic issue**: reset, push 4'h1 with `busy` = 0 → `cmd` = 4'h1 for 2 cycles with `cmd_valid` on the first, then `cmd` = 4'hF; `cmd_count` = 1.
- **Busy gating and full**: hold `busy` = 1 and push 9 commands → first 8 accepted, `host_ready` = 0 after the 8th, 9th refused and `dropped` = 1. Release `busy` → 8 commands issue in order, spaced ≥ 3 cycles apart.
- **Write completion**: push 4'h5, 4'h0, 4'h3; pulse `done` 10 cycles after 4'h0 issues → `cmd` stays 4'h0 until done, `seq_done` = 1 next cycle, 4'h3 never issued, `cmd_count` = 2, `host_ready` = 0.
- **Timeout**: `DONE_TIMEOUT` = 15, issue 4'h0, never assert `done` → `timeout` = 1 and `seq_done` = 1 exactly 15 cycles after entering WAIT_DONE.
- **Reset mid-operation**: assert `reset` during HOLD of 4'h6 → next cycle `cmd` = 4'hF, FIFO empty, all flags 0, and a fresh push issues normally.
- **Saturation**: issue 260 non-write commands → `cmd_count` = 255.
